// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, stall depths and match helper for the hazard unit
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] STALL_LOAD   = 2'd1;
    localparam logic [1:0] STALL_BR_EX  = 2'd2;
    localparam logic [1:0] STALL_BR_MEM = 2'd1;
    localparam logic [1:0] STALL_FLAGS  = 2'd1;
    localparam int         CNT_W        = 16;

    // r0 is hardwired zero, so a write to it never creates a dependence
    function automatic logic producer_match(input logic [3:0] rd, input logic we,
                                            input logic [3:0] src);
        return we && (rd != 4'd0) && (rd == src);
    endfunction

    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational stall-depth calculation from ID operands and older producers
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [3:0] if_id_rs,
    input  logic [3:0] if_id_rt,
    input  logic       if_id_uses_rs,
    input  logic       if_id_uses_rt,
    input  logic       if_id_store,
    input  logic       if_id_branch,
    input  logic       if_id_br_reg,
    input  logic [3:0] id_ex_rd,
    input  logic       id_ex_write_reg,
    input  logic       id_ex_mem_read,
    input  logic       id_ex_sets_flags,
    input  logic [3:0] ex_mem_rd,
    input  logic       ex_mem_write_reg,
    output logic [1:0] need
);

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic flags;

    always_comb begin
        // SW data operand is served by the MEM-to-MEM bypass, so only its address counts
        load_use = id_ex_mem_read &&
                   ((if_id_uses_rs && producer_match(id_ex_rd, id_ex_write_reg, if_id_rs)) ||
                    (if_id_uses_rt && !if_id_store &&
                     producer_match(id_ex_rd, id_ex_write_reg, if_id_rt)));
        br_ex  = if_id_br_reg && producer_match(id_ex_rd, id_ex_write_reg, if_id_rs);
        br_mem = if_id_br_reg && producer_match(ex_mem_rd, ex_mem_write_reg, if_id_rs);
        flags  = if_id_branch && id_ex_sets_flags;

        need = 2'd0;
        if (load_use) need = max_need(need, STALL_LOAD);
        if (br_ex)    need = max_need(need, STALL_BR_EX);
        if (br_mem)   need = max_need(need, STALL_BR_MEM);
        if (flags)    need = max_need(need, STALL_FLAGS);
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/halt FSM for the WISC pipeline; HAZARD_PERF_CNT_EN adds perf counters
module hazard_unit
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  if_id_rs,
    input  logic [3:0]  if_id_rt,
    input  logic        if_id_uses_rs,
    input  logic        if_id_uses_rt,
    input  logic        if_id_store,
    input  logic        if_id_branch,
    input  logic        if_id_br_reg,
    input  logic        if_id_halt,
    input  logic        branch_taken,
    input  logic [3:0]  id_ex_rd,
    input  logic        id_ex_write_reg,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_sets_flags,
    input  logic [3:0]  ex_mem_rd,
    input  logic        ex_mem_write_reg,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    state_t     state, state_next;
    logic [1:0] cnt, cnt_next;
    logic [1:0] need;

    hazard_detect u_detect (
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_uses_rs    (if_id_uses_rs),
        .if_id_uses_rt    (if_id_uses_rt),
        .if_id_store      (if_id_store),
        .if_id_branch     (if_id_branch),
        .if_id_br_reg     (if_id_br_reg),
        .id_ex_rd         (id_ex_rd),
        .id_ex_write_reg  (id_ex_write_reg),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_sets_flags (id_ex_sets_flags),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_write_reg (ex_mem_write_reg),
        .need             (need)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        halted         = 1'b0;
        // reset overrides every state so the pipeline sees a clean run condition
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                        cnt_next       = need - 2'd1;
                        state_next     = (need > 2'd1) ? ST_STALL : ST_RUN;
                    end else if (if_id_halt) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        state_next     = ST_HALT;
                    end else if (branch_taken) begin
                        if_id_flush    = 1'b1;
                    end
                end
                ST_STALL: begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    cnt_next       = cnt - 2'd1;
                    if (cnt <= 2'd1) state_next = ST_RUN;
                end
                ST_HALT: begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    halted         = 1'b1;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (id_ex_bubble && (state != ST_HALT) && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (if_id_flush && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with directed vectors
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic        if_id_uses_rs, if_id_uses_rt, if_id_store, if_id_branch, if_id_br_reg;
    logic        if_id_halt, branch_taken, id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags;
    logic        ex_mem_write_reg;
    logic        pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, halted;
    logic [15:0] stall_cycles, flush_count;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .if_id_store(if_id_store), .if_id_branch(if_id_branch), .if_id_br_reg(if_id_br_reg),
        .if_id_halt(if_id_halt), .branch_taken(branch_taken),
        .id_ex_rd(id_ex_rd), .id_ex_write_reg(id_ex_write_reg),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_sets_flags(id_ex_sets_flags),
        .ex_mem_rd(ex_mem_rd), .ex_mem_write_reg(ex_mem_write_reg),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, halted}
    localparam logic [4:0] NORM = 5'b11000;
    localparam logic [4:0] STL  = 5'b00100;
    localparam logic [4:0] FLS  = 5'b11010;
    localparam logic [4:0] HDEC = 5'b00000;
    localparam logic [4:0] HLT  = 5'b00101;
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [15:0] EXP_SC = 16'd3;
    localparam logic [15:0] EXP_FC = 16'd2;
`else
    localparam logic [15:0] EXP_SC = 16'd0;
    localparam logic [15:0] EXP_FC = 16'd0;
`endif

    typedef struct {
        string       name;
        logic [4:0]  o;
        logic        chk;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [4:0] act;
            e   = q.pop_front();
            act = {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, halted};
            tests++;
            if (act !== e.o) begin
                fails++;
                $display("FAIL %s: outputs got %b expected %b", e.name, act, e.o);
            end
            if (e.chk) begin
                tests++;
                if ({stall_cycles, flush_count} !== {e.sc, e.fc}) begin
                    fails++;
                    $display("FAIL %s: counters got %0d/%0d expected %0d/%0d",
                             e.name, stall_cycles, flush_count, e.sc, e.fc);
                end
            end
        end
    end

    task automatic idle();
        {if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd} = '0;
        {if_id_uses_rs, if_id_uses_rt, if_id_store, if_id_branch, if_id_br_reg} = '0;
        {if_id_halt, branch_taken, id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags} = '0;
        ex_mem_write_reg = 1'b0;
    endtask

    task automatic go(input string n, input logic [4:0] o, input logic chk = 1'b0,
                      input logic [15:0] sc = 16'd0, input logic [15:0] fc = 16'd0);
        exp_t e;
        e.name = n; e.o = o; e.chk = chk; e.sc = sc; e.fc = fc;
        q.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_use(input logic [3:0] r);
        id_ex_mem_read = 1'b1; id_ex_write_reg = 1'b1; id_ex_rd = r;
        if_id_rs = r; if_id_uses_rs = 1'b1;
    endtask

    task automatic br_on_ex(input logic [3:0] r, input logic taken);
        id_ex_write_reg = 1'b1; id_ex_rd = r;
        if_id_branch = 1'b1; if_id_br_reg = 1'b1; if_id_uses_rs = 1'b1; if_id_rs = r;
        branch_taken = taken;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1; load_use(4'd3);
        go("reset_masks_detect", NORM);
        rst = 1'b0;
        go("after_reset", NORM);

        load_use(4'd3);
        go("load_use_stall", STL);
        go("load_use_release", NORM);

        id_ex_mem_read = 1'b1; id_ex_write_reg = 1'b1; id_ex_rd = 4'd3;
        if_id_store = 1'b1; if_id_uses_rs = 1'b1; if_id_uses_rt = 1'b1;
        if_id_rs = 4'd5; if_id_rt = 4'd3;
        go("sw_data_no_stall", NORM);

        br_on_ex(4'd4, 1'b1);
        go("br_ex_stall1", STL);
        ex_mem_write_reg = 1'b1; ex_mem_rd = 4'd4;
        if_id_branch = 1'b1; if_id_br_reg = 1'b1; if_id_uses_rs = 1'b1; if_id_rs = 4'd4;
        branch_taken = 1'b1;
        go("br_ex_stall2", STL);
        if_id_branch = 1'b1; if_id_br_reg = 1'b1; if_id_uses_rs = 1'b1; if_id_rs = 4'd4;
        branch_taken = 1'b1;
        go("br_flush", FLS);
        go("after_flush", NORM);

        ex_mem_write_reg = 1'b1; ex_mem_rd = 4'd6;
        if_id_branch = 1'b1; if_id_br_reg = 1'b1; if_id_uses_rs = 1'b1; if_id_rs = 4'd6;
        go("br_mem_stall", STL);
        go("br_mem_release", NORM);

        id_ex_sets_flags = 1'b1; if_id_branch = 1'b1;
        go("flags_stall", STL);
        go("flags_release", NORM);

        load_use(4'd0);
        go("load_r0_no_stall", NORM);
        br_on_ex(4'd0, 1'b0);
        go("br_r0_no_stall", NORM);
        load_use(4'd7); if_id_uses_rs = 1'b0;
        go("unused_rs_no_stall", NORM);

        br_on_ex(4'd9, 1'b0);
        go("stall_before_rst", STL);
        rst = 1'b1; br_on_ex(4'd9, 1'b0);
        go("rst_mid_stall", NORM);
        rst = 1'b0;
        go("after_rst_mid_stall", NORM);

        if_id_halt = 1'b1;
        go("halt_decode", HDEC);
        for (int i = 0; i < 3; i++) begin
            load_use(4'd2); branch_taken = 1'b1; if_id_halt = 1'b1;
            go("halted_hold", HLT);
        end
        rst = 1'b1;
        go("rst_in_halt", NORM);
        rst = 1'b0;
        go("counters_cleared", NORM, 1'b1, 16'd0, 16'd0);

        for (int i = 0; i < 3; i++) begin
            load_use(4'd8);
            go("cnt_load_use", STL);
            go("cnt_release", NORM);
        end
        branch_taken = 1'b1;
        go("cnt_flush1", FLS);
        branch_taken = 1'b1;
        go("cnt_flush2", FLS);
        go("counters_final", NORM, 1'b1, EXP_SC, EXP_FC);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and flush controller for the 5-stage WISC pipeline, the other end of the bypass network: it covers every RAW hazard the forwarding paths cannot resolve and every control hazard from ID-stage branch resolution. It sits beside the ID stage, drives PC and IF/ID write enables, inserts bubbles into ID/EX and flushes IF/ID. A small FSM holds multi-cycle stalls and latches HLT.

## Interface
- Parameters: none.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- if_id_rs, if_id_rt  in  4  source registers of the instruction in ID.
- if_id_uses_rs, if_id_uses_rt  in  1  the ID instruction actually reads rs/rt.
- if_id_store  in  1  ID instruction is SW; its rt is data, not address.
- if_id_branch  in  1  ID instruction is B or BR.
- if_id_br_reg  in  1  ID instruction is BR (target from rs).
- if_id_halt  in  1  ID instruction is HLT.
- branch_taken  in  1  ID branch resolved taken this cycle.
- id_ex_rd  in  4;  id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags  in  1 each.
- ex_mem_rd  in  4;  ex_mem_write_reg  in  1.
- pc_write_en  out  1  PC may update.
- if_id_write_en  out  1  IF/ID may capture.
- id_ex_bubble  out  1  load NOP control into ID/EX.
- if_id_flush  out  1  squash IF/ID contents.
- halted  out  1  HLT reached; pipeline frozen at fetch.
- stall_cycles  out  16  stall-cycle count (see Configuration).
- flush_count  out  16  taken-branch flush count (see Configuration).

## Operation
- Producer match P(rd, we) = we & (rd != 0) & (rd == consumer reg); rs checked if if_id_uses_rs, rt if if_id_uses_rt.
- Load-use: id_ex_mem_read & P on rs, or on rt when !if_id_store (SW rt covered by MEM-MEM bypass) -> need 1.
- Branch register (if_id_br_reg, rs): P(id_ex) -> need 2; P(ex_mem) -> need 1 (only MEM/WB->ID bypass exists).
- Branch flags: if_id_branch & id_ex_sets_flags -> need 1.
- need = max of all sources; 0 = no hazard.
- FSM states RUN, STALL, HALT (encoding in package).
- RUN, need>0: stall this cycle (pc_write_en=0, if_id_write_en=0, id_ex_bubble=1); cnt <= need-1; if need-1>0 go STALL else stay RUN.
- RUN, need=0, branch_taken: if_id_flush=1 for one cycle, PC/IF/ID enabled.
- RUN, need=0, if_id_halt: pc_write_en=0, if_id_write_en=0, go HALT.
- STALL: stall asserted; new detection ignored; branch_taken/if_id_halt ignored; cnt decrements; at cnt=0 after this cycle -> RUN (hazard re-evaluated next cycle).
- HALT: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, halted=1; exit only by rst.
- Priority: rst > HALT > stall > halt decode > flush.

## Timing
- Detection/outputs combinational from inputs and state, same cycle; state and cnt registered on clk.
- While rst=1 and the cycle after: state RUN, cnt 0, pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0, halted=0, counters 0; detection masked while rst=1.
- Load-use: 1 stall cycle. BR on ID/EX producer: 2 consecutive stall cycles. BR on EX/MEM producer or flag dependence: 1.
- rst mid-STALL or in HALT: RUN next cycle, stall deasserted.
- Taken branch on a stalled cycle produces no flush; flush occurs on the cycle the branch resolves unstalled.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles increments on every cycle with id_ex_bubble=1 outside HALT; flush_count increments on every if_id_flush; both saturate at 16'hFFFF, cleared by rst.
- Undefined: both ports present, tied to 16'h0000, no counter flops.

## Structure
- hazard_pkg: state enum (RUN, STALL, HALT), STALL_LOAD=1, STALL_BR_EX=2, STALL_BR_MEM=1, STALL_FLAGS=1, 16-bit counter width.
- One sub-module hazard_detect: purely combinational, computes need (2 bits) from match inputs; FSM and counters stay in hazard_unit.

## Test plan
- LW r3 in ID/EX (id_ex_mem_read=1, rd=3), ADD using rs=3 in ID -> one cycle pc_write_en=0, id_ex_bubble=1, then RUN.
- LW r3 in ID/EX, SW with rt=3, rs=5 in ID -> no stall.
- ADD rd=4 in ID/EX, BR rs=4 in ID -> exactly 2 stall cycles; branch_taken during them gives no flush; third cycle branch_taken=1 -> if_id_flush=1 one cycle.
- Writer to rd=0 in ID/EX with LW/BR dependence on r0 -> no stall.
- HLT in ID, need=0 -> halted=1 next cycle and forever; rst pulse -> halted=0, pc_write_en=1.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls + 2 taken branches -> stall_cycles=3, flush_count=2; without macro both 0.
